// File: rtl/pool_rf_ctrl.sv
// pool_rf_ctrl
// 2x2, stride-2 max-pooling sequencer for the external 16-entry pooling
// register file. Pixels arrive in raster order, two horizontally adjacent
// pixels per beat. Even rows are parked in the register file. Each odd-row
// beat is merged with the two stored pixels above it, which are fetched one
// at a time through the single read port. The window maximum is then offered
// on a valid/ready output.
//
// Build option:
//   POOL_SIGNED_EN  when defined, max comparisons treat pixels as
//                   two's-complement signed values. The default is unsigned,
//                   for post-ReLU data. Timing, interface and reset values
//                   are the same in both builds.
//
// Ports:
//   clk                   clock
//   nrst                  asynchronous active-low reset
//   clr                   synchronous soft clear, abandons the current frame
//   in_valid / in_ready   input beat handshake
//   in_pix0 / in_pix1     left (even column) / right (odd column) pixel
//   out_valid / out_ready pooled-window handshake
//   out_pix               window maximum
//   out_last              marks the final window of a frame
//   rf_wr                 register-file write enable (both write ports)
//   rf_add_in1/rf_in1     write port 1: left pixel, address 2k
//   rf_add_in2/rf_in2     write port 2: right pixel, address 2k+1
//   rf_add_out            register-file read address
//   rf_rdata              combinational read data for rf_add_out
//
// state | meaning
// FILL  | even row: write each accepted pixel pair to RF addresses 2k/2k+1
// ACC   | odd row: wait for a beat, keep the max of the two new pixels
// RD0   | read stored left pixel (2k), fold it into the running max
// RD1   | read stored right pixel (2k+1), register the window result
// OUT   | present the result until out_ready

module pool_rf_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int COLS       = 8,   // even, 2..16, so that 2k+1 fits a 4-bit address
  parameter int ROWS       = 8    // even, >= 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pix0,
  input  logic [DATA_WIDTH-1:0] in_pix1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pix,
  output logic                  out_last,
  output logic                  rf_wr,
  output logic [3:0]            rf_add_in1,
  output logic [3:0]            rf_add_in2,
  output logic [DATA_WIDTH-1:0] rf_in1,
  output logic [DATA_WIDTH-1:0] rf_in2,
  output logic [3:0]            rf_add_out,
  input  logic [DATA_WIDTH-1:0] rf_rdata
);

  localparam int KMAX = COLS / 2 - 1;
  localparam int RMAX = ROWS / 2 - 1;
  localparam int KW   = (COLS / 2 > 1) ? $clog2(COLS / 2) : 1;
  localparam int RW   = (ROWS / 2 > 1) ? $clog2(ROWS / 2) : 1;

  typedef enum logic [2:0] {
    S_FILL = 3'd0,
    S_ACC  = 3'd1,
    S_RD0  = 3'd2,
    S_RD1  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [RW-1:0]         r_q, r_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] out_pix_q, out_pix_d;
  logic                  out_last_q, out_last_d;

  logic                  k_last;
  logic                  r_last;
  logic [3:0]            addr_even;
  logic [3:0]            addr_odd;

  // Comparison without width growth; on a tie either operand is correct.
  function automatic logic [DATA_WIDTH-1:0] pmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
`ifdef POOL_SIGNED_EN
    return ($signed(a) > $signed(b)) ? a : b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

  assign k_last    = (k_q == KW'(KMAX));
  assign r_last    = (r_q == RW'(RMAX));
  assign addr_even = 4'(k_q) << 1;
  assign addr_odd  = addr_even | 4'd1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_FILL;
      k_q        <= '0;
      r_q        <= '0;
      acc_q      <= '0;
      out_pix_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      r_q        <= r_d;
      acc_q      <= acc_d;
      out_pix_q  <= out_pix_d;
      out_last_q <= out_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    r_d        = r_q;
    acc_d      = acc_q;
    out_pix_d  = out_pix_q;
    out_last_d = out_last_q;
    in_ready   = 1'b0;
    rf_wr      = 1'b0;
    rf_add_in1 = 4'd0;
    rf_add_in2 = 4'd0;
    rf_in1     = '0;
    rf_in2     = '0;
    rf_add_out = 4'd0;

    case (state_q)
      S_FILL: begin
        in_ready = 1'b1;
        // A beat that coincides with clr is dropped, so it must not touch the RF.
        if (in_valid && !clr) begin
          rf_wr      = 1'b1;
          rf_add_in1 = addr_even;
          rf_add_in2 = addr_odd;
          rf_in1     = in_pix0;
          rf_in2     = in_pix1;
          if (k_last) begin
            k_d     = '0;
            state_d = S_ACC;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = pmax(in_pix0, in_pix1);
          state_d = S_RD0;
        end
      end

      S_RD0: begin
        rf_add_out = addr_even;
        acc_d      = pmax(acc_q, rf_rdata);
        state_d    = S_RD1;
      end

      S_RD1: begin
        rf_add_out = addr_odd;
        out_pix_d  = pmax(acc_q, rf_rdata);
        out_last_d = k_last && r_last;
        state_d    = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          if (!k_last) begin
            k_d     = k_q + KW'(1);
            state_d = S_ACC;
          end else begin
            k_d     = '0;
            r_d     = r_last ? '0 : r_q + RW'(1);
            state_d = S_FILL;
          end
        end
      end

      default: begin
        state_d = S_FILL;
        k_d     = '0;
        r_d     = '0;
      end
    endcase

    // Soft clear wins over any handshake in the same cycle.
    if (clr) begin
      state_d = S_FILL;
      k_d     = '0;
      r_d     = '0;
    end
  end

  assign out_valid = (state_q == S_OUT);
  assign out_pix   = out_pix_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_pool_rf_ctrl.sv
module tb_pool_rf_ctrl;

  localparam int DW   = 8;
  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int NP   = COLS / 2;      // beats per row
  localparam int FB   = NP * ROWS;     // beats per frame

  logic          clk = 1'b0;
  logic          nrst;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_pix0;
  logic [DW-1:0] in_pix1;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_pix;
  logic          out_last;
  logic          rf_wr;
  logic [3:0]    rf_add_in1;
  logic [3:0]    rf_add_in2;
  logic [DW-1:0] rf_in1;
  logic [DW-1:0] rf_in2;
  logic [3:0]    rf_add_out;
  logic [DW-1:0] rf_rdata;

  pool_rf_ctrl #(.DATA_WIDTH(DW), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .clr        (clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pix0    (in_pix0),
    .in_pix1    (in_pix1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pix    (out_pix),
    .out_last   (out_last),
    .rf_wr      (rf_wr),
    .rf_add_in1 (rf_add_in1),
    .rf_add_in2 (rf_add_in2),
    .rf_in1     (rf_in1),
    .rf_in2     (rf_in2),
    .rf_add_out (rf_add_out),
    .rf_rdata   (rf_rdata)
  );

  always #5 clk = ~clk;

  // Pooling register file: two write ports, one combinational read port.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (rf_wr) begin
      mem[rf_add_in1] <= rf_in1;
      mem[rf_add_in2] <= rf_in2;
    end
  end
  assign rf_rdata = mem[rf_add_out];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] pix;
    logic          last;
  } win_t;

  logic [DW-1:0] frm [ROWS][COLS];
  win_t          exp_q [$];

  function automatic logic [DW-1:0] maxw(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef POOL_SIGNED_EN
    return ($signed(a) > $signed(b)) ? a : b;
`else
    return (a > b) ? a : b;
`endif
  endfunction

  function automatic logic [DW-1:0] rnd_pix();
    case ($urandom_range(0, 7))
      0:       return 8'd0;
      1:       return 8'd255;
      2:       return 8'd128;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // mode 0: random; 1: basic-window rows; 2: stored-row maximum corner case
  task automatic build_frame(input int mode);
    for (int rr = 0; rr < ROWS; rr++)
      for (int cc = 0; cc < COLS; cc++)
        frm[rr][cc] = rnd_pix();
    if (mode == 1) begin
      for (int cc = 0; cc < COLS; cc++) begin
        frm[0][cc] = 8'(cc);
        frm[1][cc] = 8'(cc);
      end
      frm[1][0] = 8'd10;
      frm[1][3] = 8'd20;
    end else if (mode == 2) begin
      frm[0][0] = 8'd200;
      frm[0][1] = 8'd3;
      frm[1][0] = 8'd1;
      frm[1][1] = 8'd2;
    end
    for (int rp = 0; rp < ROWS / 2; rp++)
      for (int kk = 0; kk < NP; kk++) begin
        win_t w;
        w.pix  = maxw(maxw(frm[2*rp][2*kk], frm[2*rp+1][2*kk]),
                      maxw(frm[2*rp][2*kk+1], frm[2*rp+1][2*kk+1]));
        w.last = (rp == ROWS / 2 - 1) && (kk == NP - 1);
        exp_q.push_back(w);
      end
  endtask

  // ---------------- monitor ----------------
  int            cyc = 0;
  int            beat_cnt = 0;
  int            pend = 0;
  int            acc_edge = 0;
  int            n_out = 0;
  int            n_last = 0;
  bit            even_row;
  logic          prev_hold = 1'b0;
  logic          prev_ov = 1'b0;
  logic [DW-1:0] held_pix;
  logic          held_last;
  win_t          mw;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!nrst || clr) begin
      beat_cnt  = 0;
      pend      = 0;
      prev_hold = 1'b0;
      prev_ov   = 1'b0;
      exp_q.delete();
    end else begin
      even_row = ((beat_cnt / NP) % 2) == 0;
      check_val("in_ready", in_ready, pend == 0);
      check_val("no_ready_with_valid", in_ready && out_valid, 0);
      check_val("rf_wr", rf_wr, in_valid && even_row && pend == 0);
      if (rf_wr) begin
        check_val("rf_add_in1", rf_add_in1, 2 * (beat_cnt % NP));
        check_val("rf_add_in2", rf_add_in2, 2 * (beat_cnt % NP) + 1);
        check_val("rf_in1", rf_in1, in_pix0);
        check_val("rf_in2", rf_in2, in_pix1);
      end else begin
        check_val("rf_addr_idle", {rf_add_in1, rf_add_in2}, 0);
      end
      if (prev_hold) begin
        check_val("hold_valid", out_valid, 1);
        check_val("hold_pix", out_pix, held_pix);
        check_val("hold_last", out_last, held_last);
      end
      if (out_valid && !prev_ov) check_val("latency", cyc - acc_edge, 2);
      if (out_valid) check_val("valid_pending", pend, 1);
      if (in_valid && in_ready) begin
        if (!even_row) begin
          pend     = 1;
          acc_edge = cyc + 1;
        end
        beat_cnt = (beat_cnt + 1) % FB;
      end
      if (out_valid && out_ready) begin
        check_val("exp_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mw = exp_q.pop_front();
          check_val("out_pix", out_pix, mw.pix);
          check_val("out_last", out_last, mw.last);
        end
        pend = 0;
        n_out++;
        if (out_last) n_last++;
      end
      prev_hold = out_valid && !out_ready;
      held_pix  = out_pix;
      held_last = out_last;
      prev_ov   = out_valid;
    end
  end

  // ---------------- out_ready driver ----------------
  int or_mode = 2;   // 0 random, 1 held low, 2 held high
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (or_mode)
        0:       out_ready = ($urandom_range(0, 9) < 7);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- input driver ----------------
  task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit ok = 1'b0;
    in_pix0  = a;
    in_pix1  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_val("in_accept", ok, 1);
  endtask

  task automatic send_frame(input int mode, input int nbeats);
    build_frame(mode);
    for (int b = 0; b < nbeats; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send_beat(frm[b / NP][2 * (b % NP)], frm[b / NP][2 * (b % NP) + 1]);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_val("drain", exp_q.size(), 0);
  endtask

  task automatic wait_out_valid(input string tag);
    bit seen = 1'b0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check_val(tag, seen, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  int base_out;
  int base_last;

  initial begin
    nrst      = 1'b0;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_pix0   = '0;
    in_pix1   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_pix", out_pix, 0);
    check_val("rst_out_last", out_last, 0);
    check_val("rst_rf_wr", rf_wr, 0);
    check_val("rst_rf_add_out", rf_add_out, 0);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    // basic window then stored-row maximum
    or_mode = 2;
    send_frame(1, FB);
    wait_drain();
    or_mode = 0;
    send_frame(2, FB);
    wait_drain();

    // backpressure: first window held for 5 cycles
    or_mode = 1;
    fork
      send_frame(0, FB);
      begin
        wait_out_valid("bp_reach_out");
        repeat (5) @(posedge clk);
        #1;
        or_mode = 2;
      end
    join
    or_mode = 0;
    wait_drain();

    // asynchronous reset while in RD1
    or_mode = 2;
    send_frame(0, NP + 1);     // returns in the RD0 cycle
    @(posedge clk);            // now RD1
    #2;
    nrst = 1'b0;
    #1;
    check_val("rst_rd1_out_valid", out_valid, 0);
    check_val("rst_rd1_in_ready", in_ready, 1);
    check_val("rst_rd1_rf_wr", rf_wr, 0);
    @(negedge clk);
    @(posedge clk);
    #3;
    nrst = 1'b1;
    @(posedge clk);
    #1;
    or_mode = 0;
    send_frame(0, FB);
    wait_drain();

    // soft clear while a window is pending in OUT
    or_mode = 1;
    send_frame(0, NP + 1);
    wait_out_valid("clr_reach_out");
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check_val("clr_out_valid", out_valid, 0);
    check_val("clr_in_ready", in_ready, 1);
    or_mode = 0;
    send_frame(0, FB);
    wait_drain();

    // two frames back-to-back
    base_out  = n_out;
    base_last = n_last;
    send_frame(0, FB);
    send_frame(0, FB);
    wait_drain();
    check_val("b2b_windows", n_out - base_out, 2 * (ROWS / 2) * NP);
    check_val("b2b_lasts", n_last - base_last, 2);

    // randomized frames
    for (int f = 0; f < 6; f++) begin
      or_mode = (f % 3 == 2) ? 2 : 0;
      send_frame(0, FB);
    end
    wait_drain();

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_rf_ctrl.md
# pool_rf_ctrl

Sequencer for the 16-entry pooling register file in the pooling stage. It performs 2x2, stride-2 max pooling on a raster pixel stream that arrives two horizontally adjacent pixels per beat. Even rows are parked in the register file. Each odd-row beat is combined with the two stored pixels above it, read back through the single read port, and the window maximum is emitted on a valid/ready output.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width.
- COLS, 8, pixels per row; even, 2..16.
- ROWS, 8, rows per frame; even, ≥2.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous soft clear; abandons the frame.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_pix0  in  DATA_WIDTH  left pixel (even column).
- in_pix1  in  DATA_WIDTH  right pixel (odd column).
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts.
- out_pix  out  DATA_WIDTH  window maximum.
- out_last  out  1  qualifies the final window of a frame.
- rf_wr  out  1  register-file write enable (Wr_ctrl).
- rf_add_in1  out  4  write address 1 (left pixel).
- rf_add_in2  out  4  write address 2 (right pixel).
- rf_in1  out  DATA_WIDTH  write data 1.
- rf_in2  out  DATA_WIDTH  write data 2.
- rf_add_out  out  4  read address.
- rf_rdata  in  DATA_WIDTH  combinational read data from rf_add_out.

## Operation
Counters:
- k counts the column pair, 0..COLS/2-1.
- r counts the row pair, 0..ROWS/2-1.

States:
- FILL (even row):
  - in_ready=1.
  - rf_wr = in_valid, rf_add_in1=2k, rf_add_in2=2k+1, rf_in1=in_pix0, rf_in2=in_pix1.
  - On each accepted beat, k increments. When k=COLS/2-1, k returns to 0 and the next state is ACC.
- ACC (odd row):
  - in_ready=1.
  - On an accepted beat, acc <= max(in_pix0,in_pix1), then go to RD0.
- RD0:
  - in_ready=0, rf_add_out=2k.
  - acc <= max(acc,rf_rdata). Go to RD1.
- RD1:
  - in_ready=0, rf_add_out=2k+1.
  - out_pix <= max(acc,rf_rdata).
  - out_last <= (k==COLS/2-1 && r==ROWS/2-1).
  - Go to OUT.
- OUT:
  - out_valid=1, in_ready=0. Hold out_pix and out_last until out_ready.
  - On the handshake:
    - If k<COLS/2-1: k++, go to ACC.
    - Else k=0. If r<ROWS/2-1: r++, go to FILL. Otherwise r=0, go to FILL (new frame).

Datapath rules:
- rf_wr is 0 outside FILL. Write addresses and data are don't-care when rf_wr=0 and are driven to 0.
- rf_add_out is 0 outside RD0/RD1.
- Comparisons are unsigned, DATA_WIDTH wide, with no width growth. On ties either operand may be selected (the values are equal).
- The block never reads an address during the same cycle it writes it. A row's writes finish in FILL, before any ACC-row read.

Boundary behaviour:
- clr=1: next state FILL, k=r=0, out_valid=0, and any pending window is dropped. clr has priority over every handshake in the same cycle. No rf write occurs in a cycle where clr=1, so rf_wr is gated by !clr.
- out_ready held low: OUT persists indefinitely with outputs stable and no input accepted.
- in_valid low in FILL/ACC: no state change.
- nrst asserted mid-operation: immediate return to FILL, counters 0, the partial window is lost. Register-file contents are not cleared and are overwritten by the next even row.

## Timing
Reset values:
- State FILL, k=0, r=0, acc=0.
- out_valid=0, out_pix=0, out_last=0, rf_add_out=0.
- in_ready=1 (FILL). rf_wr follows in_valid, so the bench holds in_valid=0 during reset.

Write path: an FILL beat accepted at edge N is written into the register file at edge N. rf_wr, addresses and data are combinational in that cycle.

Pooling latency and throughput:
- ACC beat accepted at edge N → RD0 in cycle N+1 → RD1 in cycle N+2 → out_valid high from cycle N+3.
- Odd-row peak throughput is one window per 4 cycles with out_ready=1.
- Even-row throughput is one beat per cycle.

Handshake rules:
- out_valid, once high, stays high and out_pix/out_last stay stable until out_ready.
- in_ready is never high in the same cycle as out_valid.

## Configuration
POOL_SIGNED_EN:
- Defined: all max comparisons treat pixels as two's-complement signed DATA_WIDTH values. Use this mode when pooling precedes activation.
- Undefined (default): comparisons are unsigned, matching post-ReLU data.

Nothing else changes: timing, interface and reset values are identical in both builds.

## Test plan
- Basic window, COLS=8, ROWS=2:
  - Stimulus: row 0 pairs (0,1)(2,3)(4,5)(6,7); row 1 pairs (10,1)(2,20)(4,5)(6,7).
  - Required: outputs 10,20,5,7; out_last high only with the 7; rf writes at addresses 0..7 during row 0.
- Stored-row maximum:
  - Stimulus: row 0 (200,3); row 1 (1,2).
  - Required: output 200 unsigned. With POOL_SIGNED_EN the same stimulus yields 3 (200 ≡ -56).
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles while in OUT.
  - Required: out_valid=1 and out_pix constant; in_ready=0; rf_wr=0 throughout; exactly one output when out_ready rises.
- Reset mid-RD1:
  - Stimulus: assert nrst=0 during RD1.
  - Required: out_valid=0 immediately. The next accepted beat writes addresses 0/1 with rf_wr=1, and no stale window is emitted.
- Soft clear:
  - Stimulus: clr=1 for one cycle in OUT, then a new frame.
  - Required: out_valid=0 the next cycle; the dropped window never reappears; the new frame's results are correct.
- Two frames back-to-back, COLS=8, ROWS=4:
  - Required: 8 windows per frame; out_last asserted on the 8th and 16th outputs only; state FILL after each.
